seq_binary_to_bcd: RTL

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It takes a start/busy/done handshake and produces a registered, stable BCD result for the timer's 7-segment digit drivers. It generalises the combinational 8-bit/3-digit converter to arbitrary width and digit count, and adds overflow detection.

---
 rtl/seq_binary_to_bcd.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/seq_binary_to_bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock).
// Optional leading-zero blank outputs are compiled in when BCD_LZ_BLANK_EN is defined.
module seq_binary_to_bcd #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      binary_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  overflow_o
`ifdef BCD_LZ_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank_o
`endif
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [BIN_W-1:0]    shift_q, shift_d;
    logic [BcdW-1:0]     work_q, work_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                sticky_q, sticky_d;
    logic [BcdW-1:0]     bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    logic [BcdW-1:0]       adj;
    logic [BcdW+BIN_W-1:0] shifted;
    logic                  accept;

    // Add-3 correction on every digit, then shift the whole {bcd, binary} chain.
    always_comb begin
        adj = work_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (work_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
            end
        end
        shifted = {adj, shift_q} << 1;
    end

`ifdef BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] blank_calc;
    logic              upper_zero;

    // Digit 0 is never blanked so a zero value still shows one "0".
    always_comb begin
        blank_calc = '0;
        upper_zero = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            upper_zero    = upper_zero & (work_q[4*k +: 4] == 4'd0);
            blank_calc[k] = upper_zero;
        end
    end

    assign blank_o = blank_q;
`endif

    assign accept = start_i & ((state_q == StIdle) | (state_q == StDone));

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
`ifdef BCD_LZ_BLANK_EN
        blank_d  = blank_q;
`endif
        case (state_q)
            StIdle: ;
            StShift: begin
                shift_d  = shifted[BIN_W-1:0];
                work_d   = shifted[BcdW+BIN_W-1:BIN_W];
                sticky_d = sticky_q | adj[BcdW-1];
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                bcd_d   = work_q;
                ovf_d   = sticky_q;
                done_d  = 1'b1;
                state_d = StIdle;
`ifdef BCD_LZ_BLANK_EN
                blank_d = blank_calc;
`endif
            end
            default: state_d = StIdle;
        endcase
        // A request in DONE restarts immediately for back-to-back throughput.
        if (accept) begin
            shift_d  = binary_i;
            work_d   = '0;
            sticky_d = 1'b0;
            cnt_d    = CntW'(BIN_W - 1);
            state_d  = StShift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef BCD_LZ_BLANK_EN
            blank_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
`ifdef BCD_LZ_BLANK_EN
            blank_q  <= blank_d;
`endif
        end
    end

    assign busy_o     = (state_q == StShift);
    assign done_o     = done_q;
    assign bcd_o      = bcd_q;
    assign overflow_o = ovf_q;

endmodule
